// File: rtl/uart_tx.sv
// uart_tx -- host-side 8N1 UART transmitter with a TX FIFO.
//
// The IOC bus writes bytes into a circular FIFO; the shifter drains them
// LSB first onto txd, gated by a synchronised cts. tx_irq flags "FIFO
// empty" when enabled. Host strobes are asynchronous and are synchronised
// here. Reset is synchronous and active low.
//
// Optional build macro: UART_TX_PARITY_EN adds ctrl bit1 (par_en) and an
// even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk     main clock
//   nRST    synchronous active-low reset
//   cs      block select (already qualified with !nIOC_SEL)
//   nwe     host write strobe, active low, asynchronous
//   addr    register select: 0 data, 1 ctrl/status, 2 div lo, 3 div hi
//   din     host write data
//   dout    host read data, combinational on addr
//   cts     clear-to-send, active high, asynchronous
//   txd     serial output, idle high
//   tx_irq  level interrupt: irq_en && FIFO empty (registered)
module uart_tx #(
  parameter int                   FIFO_DEPTH  = 8,     // power of 2, 2..15
  parameter int                   DIV_WIDTH   = 16,    // 9..16
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd8
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       cs,
  input  logic       nwe,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       cts,
  output logic       txd,
  output logic       tx_irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t state, state_nx;

  // ---- synchronisers ------------------------------------------------------
  // wr_sync[2] is the delayed copy used to find the rising edge of the
  // synchronised strobe, giving exactly one wr pulse per host write.
  logic [2:0] wr_sync;
  logic [1:0] cts_sync;
  logic       wr, cts_s;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_sync  <= '0;
      cts_sync <= '0;
    end else begin
      wr_sync  <= {wr_sync[1:0], cs & ~nwe};
      cts_sync <= {cts_sync[0], cts};
    end
  end

  assign wr    = wr_sync[1] & ~wr_sync[2];
  assign cts_s = cts_sync[1];

  logic wr_fifo, wr_ctrl, wr_dlo, wr_dhi, flush;
  assign wr_fifo = wr && (addr == 2'd0);
  assign wr_ctrl = wr && (addr == 2'd1);
  assign wr_dlo  = wr && (addr == 2'd2);
  assign wr_dhi  = wr && (addr == 2'd3);
  assign flush   = wr_ctrl && din[2];

  // ---- control / divisor registers ----------------------------------------
  logic                 irq_en, overrun;
  logic [DIV_WIDTH-1:0] divisor;
  logic [15:0]          div16;
`ifdef UART_TX_PARITY_EN
  logic par_en, par_frame, par_bit;
`endif

  assign div16 = 16'(divisor);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      irq_en  <= 1'b0;
      divisor <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
      par_en  <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) irq_en <= din[0];
`ifdef UART_TX_PARITY_EN
      if (wr_ctrl) par_en <= din[1];
`endif
      if (wr_dlo) divisor <= DIV_WIDTH'({div16[15:8], din});
      if (wr_dhi) divisor <= DIV_WIDTH'({din, div16[7:0]});
    end
  end

  // ---- FIFO -----------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [3:0]    count;
  logic          full, empty, pop, push;

  assign full  = (count == 4'(FIFO_DEPTH));
  assign empty = (count == 4'd0);
  assign pop   = (state == S_IDLE) && !empty && cts_s;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is fine.
  assign push  = wr_fifo && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= (wptr == PW'(FIFO_DEPTH-1)) ? '0 : wptr + PW'(1);
        if (pop)  rptr <= (rptr == PW'(FIFO_DEPTH-1)) ? '0 : rptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + 4'd1;
          2'b01:   count <= count - 4'd1;
          default: ;
        endcase
      end
      if (wr_ctrl && din[3])          overrun <= 1'b0;
      else if (wr_fifo && full && !pop) overrun <= 1'b1;
    end
  end

  // ---- shifter datapath -----------------------------------------------------
  // baud_cnt reloads from the live divisor at every bit boundary, so a
  // divisor write lands on the next bit. Period = divisor + 1 clocks.
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 tick;

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
`ifdef UART_TX_PARITY_EN
      par_frame <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      if (pop || (state != S_IDLE && tick)) baud_cnt <= divisor;
      else if (state != S_IDLE)             baud_cnt <= baud_cnt - DIV_WIDTH'(1);
      if (pop) begin
        shreg   <= mem[rptr];
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par_frame <= par_en;
        par_bit   <= ^mem[rptr];
`endif
      end else if (state == S_DATA && tick) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // ---- FSM ----------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pop)  state_nx = S_START;
      S_START: if (tick) state_nx = S_DATA;
      S_DATA:  if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_nx = par_frame ? S_PARITY : S_STOP;
`else
        state_nx = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_nx = S_STOP;
`endif
      S_STOP:  if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic busy;
  always_comb begin
    txd  = 1'b1;
    busy = (state != S_IDLE);
    case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd = par_bit;
`endif
      default:  txd = 1'b1;
    endcase
  end

  // ---- interrupt and read mux ---------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRST) tx_irq <= 1'b0;
    else       tx_irq <= irq_en && empty;
  end

  always_comb begin
    case (addr)
      2'd0:    dout = 8'h00;
      2'd1:    dout = {count, overrun, busy, full, empty};
      2'd2:    dout = div16[7:0];
      default: dout = div16[15:8];
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: register table, exact-waveform frames, flow
// control, overrun, interrupt, reset and randomized traffic decoded by a
// mid-bit sampling receiver model.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       nRST, cs, nwe, cts;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       txd, tx_irq;

  int n_pass = 0, n_total = 0;

  logic [7:0] exp_bytes[$];
  logic       exp_w[$];

  uart_tx #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .DEFAULT_DIV(16'd8)) dut (
    .clk(clk), .nRST(nRST), .cs(cs), .nwe(nwe), .addr(addr), .din(din),
    .dout(dout), .cts(cts), .txd(txd), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic hwrite(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; cs = 1'b1; nwe = 1'b0;
    repeat (5) @(negedge clk);
    cs = 1'b0; nwe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    #1 v = dout;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Receiver model: find the start edge, then sample each bit mid-period.
  task automatic rx_frame(input int div, output logic [7:0] b, output bit ok);
    bit s;
    int bp, cyc, tgt;
    logic v;
    b = '0;
    wait_start(400, s);
    ok = s;
    if (!s) return;
    bp = div + 1;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      tgt = k * bp + bp / 2;
      while (cyc < tgt) begin @(negedge clk); cyc++; end
      v = txd;
      if (k == 0 && v !== 1'b0) ok = 1'b0;
      else if (k >= 1 && k <= 8) b[k-1] = v;
      else if (k == 9 && v !== 1'b1) ok = 1'b0;
    end
  endtask

  // Expected txd, one entry per clock from the first start cycle:
  // each frame is start, data LSB first, [parity], stop, each bit div+1
  // clocks, with one idle clock between back-to-back frames.
  task automatic build_wave(input int div, input bit par, input int total);
    logic [10:0] f;
    int nb;
    exp_w.delete();
    nb = par ? 11 : 10;
    foreach (exp_bytes[j]) begin
      if (j > 0) exp_w.push_back(1'b1);
      f = {1'b1, (par ? ^exp_bytes[j] : 1'b1), exp_bytes[j], 1'b0};
      for (int k = 0; k < nb; k++)
        for (int r = 0; r <= div; r++) exp_w.push_back(f[k]);
    end
    while (exp_w.size() < total) exp_w.push_back(1'b1);
  endtask

  task automatic capture_here(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (txd !== exp_w[i]) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic quiet(input int n, input string name);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  typedef struct {
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] v, got;
    logic [9:0] a5_bits;
    bit ok, ok2;
    int bad, lat, div;
    logic [7:0] rq[$];

    nRST = 1'b0; cs = 1'b0; nwe = 1'b1; addr = '0; din = '0; cts = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // reset state
    chk("reset_txd", txd, 1'b1);
    chk("reset_irq", tx_irq, 1'b0);
    rd(2'd1, v); chk("reset_status", v, 8'h01);
    rd(2'd2, v); chk("reset_div_lo", v, 8'h08);
    rd(2'd3, v); chk("reset_div_hi", v, 8'h00);
    rd(2'd0, v); chk("reset_rd0", v, 8'h00);

    // register table (cts low, nothing drains)
    tbl[0] = '{2'd2, 8'h34, 2'd2, 8'h34};
    tbl[1] = '{2'd3, 8'h12, 2'd3, 8'h12};
    tbl[2] = '{2'd0, 8'hAA, 2'd1, 8'h10};
    tbl[3] = '{2'd0, 8'hBB, 2'd1, 8'h20};
    tbl[4] = '{2'd1, 8'h04, 2'd1, 8'h01};
    tbl[5] = '{2'd1, 8'h01, 2'd0, 8'h00};
    tbl[6] = '{2'd2, 8'h03, 2'd2, 8'h03};
    tbl[7] = '{2'd3, 8'h00, 2'd3, 8'h00};
    for (int i = 0; i < 8; i++) begin
      hwrite(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, v);
      chk($sformatf("table_%0d", i), v, tbl[i].exp);
    end
    chk("irq_en_empty", tx_irq, 1'b1);

    // 8'hA5 frame, divisor 3: exact per-clock waveform
    a5_bits = 10'b11_0100_1010;
    cts = 1'b1;
    fork
      hwrite(2'd0, 8'hA5);
      begin
        wait_start(60, ok);
        chk("a5_start", ok, 1'b1);
        if (ok) begin
          bad = 0;
          for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (txd !== a5_bits[i/4]) bad++;
            if (i == 20) begin rd(2'd1, v); chk("a5_busy_empty", v, 8'h05); end
          end
          chk("a5_wave", bad, 0);
          @(negedge clk);
          chk("a5_idle_txd", txd, 1'b1);
          rd(2'd1, v); chk("a5_idle_status", v, 8'h01);
        end
      end
    join

    // interrupt
    cts = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq_before", tx_irq, 1'b1);
    hwrite(2'd0, 8'h3C);
    chk("irq_fall_push", tx_irq, 1'b0);
    cts = 1'b1;
    wait_start(20, ok);
    chk("irq_frame_start", ok, 1'b1);
    repeat (4) @(negedge clk);
    chk("irq_after_pop", tx_irq, 1'b1);
    hwrite(2'd0, 8'h96);
    chk("irq_fall_second", tx_irq, 1'b0);
    repeat (100) @(negedge clk);
    chk("irq_drained", tx_irq, 1'b1);

    // cts hold, latency, back-to-back spacing
    cts = 1'b0;
    hwrite(2'd0, 8'h5A);
    hwrite(2'd0, 8'hC3);
    quiet(30, "cts_hold");
    cts = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (txd !== 1'b0 && lat < 20);
    chk("cts_latency_le4", (lat <= 4), 1'b1);
    exp_bytes = '{8'h5A, 8'hC3};
    build_wave(3, 1'b0, 91);
    capture_here("b2b_wave");

    // cts dropped mid-frame
    cts = 1'b0;
    hwrite(2'd0, 8'h11);
    hwrite(2'd0, 8'h22);
    cts = 1'b1;
    fork
      rx_frame(3, got, ok);
      begin repeat (12) @(negedge clk); cts = 1'b0; end
    join
    chk("ctsdrop_ok", ok, 1'b1);
    chk("ctsdrop_byte", got, 8'h11);
    quiet(60, "ctsdrop_held");
    rd(2'd1, v); chk("ctsdrop_status", v, 8'h10);
    cts = 1'b1;
    rx_frame(3, got, ok);
    chk("ctsdrop_second", {ok, got}, {1'b1, 8'h22});

    // overrun
    cts = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 9; i++) hwrite(2'd0, 8'h30 + 8'(i));
    rd(2'd1, v); chk("overrun_status", v, 8'h8A);
    hwrite(2'd1, 8'h08);
    rd(2'd1, v); chk("overrun_clear", v, 8'h82);
    cts = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      rx_frame(3, got, ok);
      if (!ok || got !== 8'h30 + 8'(i)) bad++;
    end
    chk("overrun_drain", bad, 0);
    quiet(80, "overrun_ninth_absent");
    rd(2'd1, v); chk("overrun_empty", v, 8'h01);

    // randomized traffic against the receiver model
    for (int r = 0; r < 4; r++) begin
      div = $urandom_range(1, 6);
      hwrite(2'd2, 8'(div));
      hwrite(2'd3, 8'h00);
      rq.delete();
      fork
        for (int i = 0; i < 3; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          rq.push_back(b);
          hwrite(2'd0, b);
        end
        for (int i = 0; i < 3; i++) begin
          logic [7:0] g, e;
          bit k;
          rx_frame(div, g, k);
          e = (rq.size() > 0) ? rq.pop_front() : 8'hxx;
          chk($sformatf("rand_r%0d_b%0d", r, i), {k, g}, {1'b1, e});
        end
      join
      repeat (2 * (div + 1) + 4) @(negedge clk);
    end

    // reset mid-DATA
    hwrite(2'd2, 8'h03);
    hwrite(2'd1, 8'h01);
    cts = 1'b0;
    hwrite(2'd0, 8'h00);
    hwrite(2'd0, 8'hFF);
    hwrite(2'd0, 8'h0F);
    cts = 1'b1;
    wait_start(20, ok);
    chk("rst_frame_start", ok, 1'b1);
    repeat (10) @(negedge clk);
    chk("rst_pre_data_low", txd, 1'b0);
    nRST = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_txd_next", txd, 1'b1);
    chk("rst_irq", tx_irq, 1'b0);
    @(negedge clk);
    nRST = 1'b1;
    rd(2'd1, v); chk("rst_status", v, 8'h01);
    rd(2'd2, v); chk("rst_div_lo", v, 8'h08);
    rd(2'd3, v); chk("rst_div_hi", v, 8'h00);
    quiet(40, "rst_fifo_empty");
    chk("rst_irq_after", tx_irq, 1'b0);

`ifdef UART_TX_PARITY_EN
    hwrite(2'd2, 8'h03);
    cts = 1'b0;
    hwrite(2'd1, 8'h02);
    hwrite(2'd0, 8'h07);
    hwrite(2'd0, 8'h03);
    exp_bytes = '{8'h07, 8'h03};
    build_wave(3, 1'b1, 99);
    cts = 1'b1;
    wait_start(20, ok2);
    chk("par_start", ok2, 1'b1);
    if (ok2) capture_here("par_wave");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
